// File: rtl/three_eight_decoder_pkg.sv
// Shared types and constants for the 3-to-8 pulse decoder and its code FIFO.
package three_eight_decoder_pkg;

  localparam int CODE_W = 3;
  localparam int LINES  = 8;

  // Pulse-sequencer states; encodings are fixed so they read the same in waveforms.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // One-hot line pattern for a code.
  function automatic logic [LINES-1:0] onehot_of(input logic [CODE_W-1:0] code);
    logic [LINES-1:0] v;
    v       = '0;
    v[code] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/three_eight_pulse_decoder_code_fifo.sv
// Small synchronous FIFO holding pending codes; head is visible combinationally
// so the sequencer can load it on the same edge that pops it.
module code_fifo
  import three_eight_decoder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [CODE_W-1:0]         push_data,
  input  logic                      pop,
  output logic [CODE_W-1:0]         pop_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [CODE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/three_eight_pulse_decoder.sv
// Sequential 3-to-8 decoder: queued codes are replayed in arrival order as
// one-hot pulses of PULSE_LEN cycles separated by GAP idle cycles.
module three_eight_pulse_decoder
  import three_eight_decoder_pkg::*;
#(
  parameter int PULSE_LEN = 4,
  parameter int GAP       = 1,
  parameter int DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CODE_W-1:0]      in_code,
  output logic [LINES-1:0]       out_onehot,
  output logic                   out_active,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count
);

  localparam int DWELL_MAX = (PULSE_LEN > GAP) ? PULSE_LEN : GAP;
  localparam int DWELL_W   = $clog2(DWELL_MAX + 1);
  localparam logic [DWELL_W-1:0] PULSE_LOAD = DWELL_W'(PULSE_LEN - 1);
  localparam logic [DWELL_W-1:0] GAP_LOAD   = DWELL_W'((GAP > 0) ? (GAP - 1) : 0);

  state_e             state_q, state_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [LINES-1:0]   out_onehot_q, out_onehot_d;
  logic               out_active_q, out_active_d;
  logic               dwell_done, enter_pulse, enter_gap;
  logic               fifo_full, fifo_empty;
  logic [CODE_W-1:0]  fifo_head;

  assign in_ready   = !fifo_full;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;
  assign out_onehot = out_onehot_q;
  assign out_active = out_active_q;

  code_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid && in_ready),
    .push_data (in_code),
    .pop       (enter_pulse),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  // State, dwell counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      dwell_q      <= '0;
      out_onehot_q <= '0;
      out_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dwell_q      <= dwell_d;
      out_onehot_q <= out_onehot_d;
      out_active_q <= out_active_d;
    end
  end

  // Next-state: a phase ends when its dwell counter has reached zero.
  always_comb begin
    state_d    = state_q;
    dwell_done = (dwell_q == '0);
    case (state_q)
      ST_IDLE:  if (!fifo_empty) state_d = ST_PULSE;
      ST_PULSE: if (dwell_done) begin
                  if (GAP > 0)          state_d = ST_GAP;
                  else if (!fifo_empty) state_d = ST_PULSE;
                  else                  state_d = ST_IDLE;
                end
      ST_GAP:   if (dwell_done) state_d = fifo_empty ? ST_IDLE : ST_PULSE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs: every PULSE entry (including back-to-back) pops the head and reloads the counter.
  always_comb begin
    enter_pulse  = (state_d == ST_PULSE) && ((state_q != ST_PULSE) || dwell_done);
    enter_gap    = (state_d == ST_GAP) && (state_q != ST_GAP);
    dwell_d      = dwell_q - DWELL_W'(1);
    out_onehot_d = '0;
    out_active_d = 1'b0;
    if (enter_pulse) begin
      dwell_d      = PULSE_LOAD;
      out_onehot_d = onehot_of(fifo_head);
      out_active_d = 1'b1;
    end else if (state_d == ST_PULSE) begin
      out_onehot_d = out_onehot_q;
      out_active_d = 1'b1;
    end else if (enter_gap) begin
      dwell_d = GAP_LOAD;
    end else if (state_d == ST_IDLE) begin
      dwell_d = '0;
    end
  end

endmodule
